conv_kernel_scheduler: RTL and testbench

- Sequences one convolution layer over the per-channel 3x3 weight buffer.
- Drives the buffer's enable/change handshake to load one kernel at a time, then waits for weight_OK.
- Streams OUT_PIXELS pixel-beats to the PE array for that kernel, with accumulator control flags.
- Iterates input channels (inner loop) and output channels (outer loop); sits between the top-level layer controller and the Weight-Buffer/PE datapath.

---
 rtl/conv_sched_pkg.sv | 17 +
 rtl/sched_wrap_counter.sv | 38 +++
 rtl/conv_kernel_scheduler.sv | 170 +++++++++++++++++
 tb/tb_conv_kernel_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution kernel scheduler.
// Holds the FSM state encoding and the kernel geometry shared with the weight buffer.
package conv_sched_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_COMPUTE = 3'd2;
  localparam state_t ST_NEXT    = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // Kernel edge length; the weight buffer holds KERNEL_SIZE*KERNEL_SIZE weights.
  localparam int unsigned KERNEL_SIZE = 3;

endpackage

// File: rtl/sched_wrap_counter.sv
// Wrapping up-counter used for the pixel and channel loop indices.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear to 0
//   i_inc          : advance by one, wrapping to 0 after LIMIT-1
//   o_count        : registered count value
//   o_wrap         : combinational, high when an increment wraps the count
module sched_wrap_counter #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  assign o_wrap  = i_inc & (r_count == LAST);
  assign o_count = r_count;

  // Count register; clear has priority over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_wrap ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Sequences one convolution layer: loads each 3x3 kernel through the weight
// buffer handshake, then streams OUT_PIXELS pixel-beats to the PE array.
// Input channels form the inner loop, output channels the outer loop.
// Ports:
//   i_clk, i_reset  : clock, async active-low reset
//   i_start         : one-cycle layer start pulse (only honoured in IDLE)
//   i_weight_OK     : current kernel weights valid in the buffer
//   i_pe_ready      : PE array accepts a beat this cycle
//   o_wb_enable     : weight buffer enable (registered)
//   o_wb_change     : advance buffer to next kernel (registered pulse)
//   o_pix_valid     : beat issued this cycle (combinational)
//   o_pix_idx       : current pixel-beat index (registered)
//   o_in_ch_idx     : current input channel (registered)
//   o_out_ch_idx    : current output channel (registered)
//   o_acc_clear     : beat starts a fresh accumulation (combinational)
//   o_acc_last      : beat completes the accumulation (combinational)
//   o_busy          : not idle (registered)
//   o_done          : layer complete pulse (registered)
module conv_kernel_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned NUM_IN_CH  = 3,
  parameter int unsigned NUM_OUT_CH = 8,
  parameter int unsigned OUT_PIXELS = 1024,
  parameter int unsigned CH_W       = 8,
  parameter int unsigned PIX_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_weight_OK,
  input  logic             i_pe_ready,
  output logic             o_wb_enable,
  output logic             o_wb_change,
  output logic             o_pix_valid,
  output logic [PIX_W-1:0] o_pix_idx,
  output logic [CH_W-1:0]  o_in_ch_idx,
  output logic [CH_W-1:0]  o_out_ch_idx,
  output logic             o_acc_clear,
  output logic             o_acc_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CH_W-1:0] IN_LAST = CH_W'(NUM_IN_CH - 1);

  state_t r_state;
  state_t w_next_state;

  logic w_pix_valid;
  logic w_cnt_clr;
  logic w_pix_wrap;
  logic w_in_wrap;
  logic w_out_wrap;
  logic w_next_cyc;

  logic w_wb_enable_d;
  logic w_wb_change_d;
  logic w_busy_d;
  logic w_done_d;

  logic r_wb_enable;
  logic r_wb_change;
  logic r_busy;
  logic r_done;

  assign w_pix_valid = (r_state == ST_COMPUTE) & i_weight_OK & i_pe_ready;
  assign w_next_cyc  = (r_state == ST_NEXT);
  assign w_cnt_clr   = ((r_state == ST_IDLE) & i_start) | (r_state == ST_DONE);

  // Loop counters: pixel beats, then input channel, then output channel.
  sched_wrap_counter #(.W(PIX_W), .LIMIT(OUT_PIXELS)) u_pix_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_pix_valid),
    .o_count (o_pix_idx),
    .o_wrap  (w_pix_wrap)
  );

  sched_wrap_counter #(.W(CH_W), .LIMIT(NUM_IN_CH)) u_in_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_next_cyc),
    .o_count (o_in_ch_idx),
    .o_wrap  (w_in_wrap)
  );

  // Wraps only in NEXT after the very last kernel, so it marks layer end.
  sched_wrap_counter #(.W(CH_W), .LIMIT(NUM_OUT_CH)) u_out_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_in_wrap),
    .o_count (o_out_ch_idx),
    .o_wrap  (w_out_wrap)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next_state = ST_LOAD;
      ST_LOAD:    if (i_weight_OK) w_next_state = ST_COMPUTE;
      ST_COMPUTE: if (w_pix_wrap) w_next_state = ST_NEXT;
      ST_NEXT:    w_next_state = w_out_wrap ? ST_DONE : ST_LOAD;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Output decode; registered outputs are decoded from the next state so
  // they line up with the state they describe.
  always_comb begin
    w_wb_enable_d = 1'b0;
    w_wb_change_d = 1'b0;
    w_busy_d      = 1'b0;
    w_done_d      = 1'b0;
    case (w_next_state)
      ST_LOAD, ST_COMPUTE: begin
        w_wb_enable_d = 1'b1;
        w_busy_d      = 1'b1;
      end
      ST_NEXT: begin
        w_wb_enable_d = 1'b1;
        w_wb_change_d = 1'b1;
        w_busy_d      = 1'b1;
      end
      ST_DONE: begin
        w_busy_d = 1'b1;
        w_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wb_enable <= 1'b0;
      r_wb_change <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wb_enable <= w_wb_enable_d;
      r_wb_change <= w_wb_change_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  assign o_wb_enable = r_wb_enable;
  assign o_wb_change = r_wb_change;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pix_valid = w_pix_valid;
  assign o_acc_clear = w_pix_valid & (o_in_ch_idx == '0);
  assign o_acc_last  = w_pix_valid & (o_in_ch_idx == IN_LAST);

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Directed bench for conv_kernel_scheduler with a 2x2x4 layer and a simple
// weight-buffer model (weight_OK rises 10 cycles after enable/change).
module tb_conv_kernel_scheduler;

  localparam int unsigned NI = 2;
  localparam int unsigned NO = 2;
  localparam int unsigned NP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        weight_ok;
  logic        pe_ready;
  logic        wb_enable, wb_change, pix_valid, acc_clear, acc_last, busy, done;
  logic [15:0] pix_idx;
  logic [7:0]  in_ch_idx, out_ch_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int wok_cnt = 0;
  int drop_left = 0;
  int beats = 0;
  int changes = 0;
  int dones = 0;
  int done_cyc = -1;
  bit bp_mode = 1'b0;
  bit start_req = 1'b0;

  conv_kernel_scheduler #(
    .NUM_IN_CH (NI),
    .NUM_OUT_CH(NO),
    .OUT_PIXELS(NP),
    .CH_W      (8),
    .PIX_W     (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_start     (start),
    .i_weight_OK (weight_ok),
    .i_pe_ready  (pe_ready),
    .o_wb_enable (wb_enable),
    .o_wb_change (wb_change),
    .o_pix_valid (pix_valid),
    .o_pix_idx   (pix_idx),
    .o_in_ch_idx (in_ch_idx),
    .o_out_ch_idx(out_ch_idx),
    .o_acc_clear (acc_clear),
    .o_acc_last  (acc_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, then sample and score.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!wb_enable || wb_change) wok_cnt = 0;
    else wok_cnt++;
    weight_ok = (wok_cnt >= 10) && (drop_left == 0);
    if (drop_left > 0) drop_left--;
    pe_ready = bp_mode ? (((cyc - s_cyc) % 2) == 1) : 1'b1;
    start = start_req;
    start_req = 1'b0;
    #1;
    if (pix_valid) begin
      check("beat_pix", 32'(pix_idx), 32'(beats % NP));
      check("beat_in_ch", 32'(in_ch_idx), 32'((beats / NP) % NI));
      check("beat_out_ch", 32'(out_ch_idx), 32'(beats / (NP * NI)));
      check("beat_acc_clear", 32'(acc_clear), 32'(((beats / NP) % NI) == 0));
      check("beat_acc_last", 32'(acc_last), 32'(((beats / NP) % NI) == NI - 1));
      check("beat_qual", 32'({weight_ok, pe_ready}), 32'd3);
      beats++;
    end else begin
      check("idle_acc_flags", 32'({acc_clear, acc_last}), 32'd0);
    end
    if (wb_change) changes++;
    if (done) begin
      dones++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  task automatic new_layer();
    beats = 0;
    changes = 0;
    dones = 0;
    done_cyc = -1;
    start_req = 1'b1;
    s_cyc = cyc + 1;
    step();
    step();
    check("load_after_start", 32'({busy, wb_enable, wb_change, done}), 32'b1100);
  endtask

  task automatic run_until_beats(input int n, input int max_cyc);
    int k = 0;
    while (beats < n && k < max_cyc) begin
      step();
      k++;
    end
    check("reach_beats", 32'(beats), 32'(n));
  endtask

  task automatic finish_layer(input int exp_lat);
    int k = 0;
    while (dones == 0 && k < 400) begin
      step();
      k++;
    end
    check("done_seen", 32'(dones), 32'd1);
    check("done_latency", 32'(done_cyc - s_cyc), 32'(exp_lat));
    step();
    check("idle_after_done", 32'({busy, wb_enable, wb_change, done}), 32'd0);
    check("counters_after_done", {pix_idx, in_ch_idx, out_ch_idx}, 32'd0);
    step();
    step();
    check("layer_beats", 32'(beats), 32'(NP * NI * NO));
    check("layer_changes", 32'(changes), 32'(NI * NO));
    check("layer_dones", 32'(dones), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    weight_ok = 1'b0;
    pe_ready = 1'b0;

    // Reset and idle.
    repeat (3) step();
    check("reset_ctrl", 32'({busy, wb_enable, wb_change, pix_valid, done}), 32'd0);
    check("reset_cnt", {pix_idx, in_ch_idx, out_ch_idx}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_ctrl", 32'({busy, wb_enable, wb_change, pix_valid, acc_clear, acc_last, done}), 32'd0);
      check("idle_cnt", {pix_idx, in_ch_idx, out_ch_idx}, 32'd0);
    end

    // Full layer, PE always ready: 4 kernels x (10 load + 4 beats + 1 next) + done.
    new_layer();
    finish_layer(61);

    // Backpressure: pe_ready on alternate cycles, 18 cycles per kernel.
    bp_mode = 1'b1;
    new_layer();
    finish_layer(73);
    bp_mode = 1'b0;

    // weight_OK drops for 3 cycles with pix_idx at 2.
    new_layer();
    run_until_beats(2, 100);
    drop_left = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_no_valid", 32'(pix_valid), 32'd0);
      check("drop_pix_frozen", 32'(pix_idx), 32'd2);
      check("drop_still_busy", 32'({busy, wb_enable, wb_change}), 32'b110);
    end
    step();
    check("drop_resume_valid", 32'(pix_valid), 32'd1);
    check("drop_resume_pix", 32'(pix_idx), 32'd2);
    finish_layer(64);

    // start while busy at pixel 2 is ignored.
    new_layer();
    run_until_beats(2, 100);
    start_req = 1'b1;
    step();
    check("busy_start_pix", 32'(pix_idx), 32'd2);
    step();
    check("busy_start_cont", 32'({busy, pix_idx[1:0]}), 32'b111);
    finish_layer(61);

    // Reset during COMPUTE of the second kernel.
    new_layer();
    run_until_beats(6, 100);
    check("pre_reset_state", 32'({busy, wb_enable, in_ch_idx[0]}), 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 32'({busy, wb_enable, wb_change, pix_valid, acc_clear, acc_last, done}), 32'd0);
    check("async_reset_cnt", {pix_idx, in_ch_idx, out_ch_idx}, 32'd0);
    repeat (3) step();
    check("reset_no_done", 32'(dones), 32'd0);
    rst_n = 1'b1;
    step();
    new_layer();
    finish_layer(61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
